// File: rtl/sl_pkg.sv
// Shared types, limits and symbol helpers for the serial-line transmit scheduler.
package sl_pkg;

  localparam int WLEN_MIN       = 8;
  localparam int WLEN_MAX       = 32;
  localparam int BIT_CYCLES_DEF = 16;
  localparam int GAP_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ACTIVE,
    S_GAP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SYM_ZERO,
    SYM_ONE,
    SYM_STOP,
    SYM_IDLE
  } sym_t;

  function automatic logic [5:0] clamp_wlen(input logic [5:0] w);
    if (w < 6'(WLEN_MIN)) return 6'(WLEN_MIN);
    if (w > 6'(WLEN_MAX)) return 6'(WLEN_MAX);
    return w;
  endfunction

  // Expects an already clamped length (8..32).
  function automatic logic [31:0] wlen_mask(input logic [5:0] w);
    if (w >= 6'd32) return '1;
    return (32'h1 << w) - 32'h1;
  endfunction

  function automatic logic odd_parity_bit(input logic [31:0] d, input logic [5:0] w);
    return ~^(d & wlen_mask(w));
  endfunction

  // Symbol index runs over data bits, then the optional parity symbol, then stop.
  function automatic sym_t sym_at(input logic [31:0] d, input logic [5:0] w,
                                  input logic par, input logic [5:0] idx);
    if (idx < w) return d[idx[4:0]] ? SYM_ONE : SYM_ZERO;
    if (par && (idx == w)) return odd_parity_bit(d, w) ? SYM_ONE : SYM_ZERO;
    return SYM_STOP;
  endfunction

  // Returns {sl0, sl1}; each line is pulled low to signal its value.
  function automatic logic [1:0] sym_lines(input sym_t s);
    case (s)
      SYM_ZERO: return 2'b01;
      SYM_ONE:  return 2'b10;
      SYM_STOP: return 2'b00;
      default:  return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/sl_rr_arbiter.sv
// Round-robin pick: search starts one past the pointer and wraps; one-hot and index out.
module sl_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = IDX_W'((int'(ptr) + gi + 1) % NREQ);
    end
  endgenerate

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[cand[k]]) begin
        any = 1'b1;
        idx = cand[k];
      end
    end
  end

  assign gnt = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/sl_tx_scheduler.sv
// Round-robin serial-line word transmitter with symbol/gap timing.
// Optional parity symbol enabled by defining SL_TX_PARITY_EN.
module sl_tx_scheduler
  import sl_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  localparam int IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               cfg_enable,
  input  logic [5:0]         cfg_wlen,
  input  logic               cfg_parity_en,
  output logic               sl0,
  output logic               sl1,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_id,
  output logic               done
);

  localparam int CNT_MAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [NREQ-1:0]  req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sl0_q, sl0_d;
  logic             sl1_q, sl1_d;
  logic [31:0]      data_q, data_d;
  logic [5:0]       wlen_q, wlen_d;
  logic             par_q, par_d;
  logic [5:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic [31:0]      sel_data;
  logic [5:0]       last_idx;
  logic             par_cfg;

`ifdef SL_TX_PARITY_EN
  assign par_cfg = cfg_parity_en;
`else
  // Without parity support the request is dropped and par_q stays 0.
  logic unused_parity_cfg;
  assign unused_parity_cfg = cfg_parity_en;
  assign par_cfg = 1'b0;
`endif

  sl_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign sel_data = req_data[32*int'(grant_id_q) +: 32];
  assign last_idx = wlen_q + {5'd0, par_q};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    req_ready_d = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sl0_d       = sl0_q;
    sl1_d       = sl1_q;
    data_d      = data_q;
    wlen_d      = wlen_q;
    par_d       = par_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        {sl0_d, sl1_d} = sym_lines(SYM_IDLE);
        if (cfg_enable && arb_any) begin
          state_d     = S_GRANT;
          req_ready_d = arb_gnt;
          grant_id_d  = arb_idx;
          ptr_d       = arb_idx;
          busy_d      = 1'b1;
        end
      end
      // Word and configuration are latched here and held for the whole word.
      S_GRANT: begin
        data_d  = sel_data;
        wlen_d  = clamp_wlen(cfg_wlen);
        par_d   = par_cfg;
        idx_d   = '0;
        cnt_d   = '0;
        {sl0_d, sl1_d} = sym_lines(sym_at(sel_data, wlen_d, par_cfg, 6'd0));
        state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (cnt_q == CNT_W'(BIT_CYCLES - 1)) begin
          cnt_d   = '0;
          {sl0_d, sl1_d} = sym_lines(SYM_IDLE);
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (idx_q == last_idx) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + 6'd1;
            {sl0_d, sl1_d} = sym_lines(sym_at(data_q, wlen_q, par_q, idx_d));
            state_d = S_ACTIVE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDX_W'(NREQ - 1);
      grant_id_q  <= '0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sl0_q       <= 1'b1;
      sl1_q       <= 1'b1;
      data_q      <= '0;
      wlen_q      <= 6'(WLEN_MIN);
      par_q       <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sl0_q       <= sl0_d;
      sl1_q       <= sl1_d;
      data_q      <= data_d;
      wlen_q      <= wlen_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sl0       = sl0_q;
  assign sl1       = sl1_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_sl_tx_scheduler.sv
// Scoreboard bench for sl_tx_scheduler: expected grants, symbols and word lengths are queued at stimulus time.
module tb_sl_tx_scheduler;

  localparam int NREQ = 4;
  localparam int BC   = 16;
  localparam int GC   = 16;
  localparam int SYM  = BC + GC;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              cfg_enable;
  logic [5:0]        cfg_wlen;
  logic              cfg_parity_en;
  logic              sl0, sl1, busy, done;
  logic [1:0]        grant_id;

  always #5 clk = ~clk;

  sl_tx_scheduler #(.NREQ(NREQ), .BIT_CYCLES(BC), .GAP_CYCLES(GC)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .cfg_enable    (cfg_enable),
    .cfg_wlen      (cfg_wlen),
    .cfg_parity_en (cfg_parity_en),
    .sl0           (sl0),
    .sl1           (sl1),
    .busy          (busy),
    .grant_id      (grant_id),
    .done          (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [1:0] exp_sym_q[$];
  int         exp_gnt_q[$];
  int         exp_len_q[$];

  int   cyc = 0;
  int   t0 = 0;
  int   grant_cyc = 0;
  int   done_cyc = 0;
  int   first_sym_cyc = -1;
  int   gnt_count = 0;
  int   done_count = 0;
  int   ready1_cnt = 0;
  bit   mon_en = 1'b0;
  logic [1:0] prev_lines = 2'b11;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int eff_wlen(input int w);
    if (w < 8) return 8;
    if (w > 32) return 32;
    return w;
  endfunction

  task automatic push_word(input int id, input logic [31:0] d, input int wlen, input bit par);
    int w;
    int ones;
    int p;
    w = eff_wlen(wlen);
    ones = 0;
    p = 0;
    for (int b = 0; b < w; b++) begin
      exp_sym_q.push_back(d[b] ? 2'b10 : 2'b01);
      ones += int'(d[b]);
    end
    if (par) begin
`ifdef SL_TX_PARITY_EN
      exp_sym_q.push_back((ones % 2 == 0) ? 2'b10 : 2'b01);
      p = 1;
`endif
    end
    exp_sym_q.push_back(2'b00);
    exp_gnt_q.push_back(id);
    exp_len_q.push_back((w + p + 1) * SYM);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (req_ready[1]) ready1_cnt++;
      if (req_ready != '0) begin
        gnt_count++;
        grant_cyc = cyc;
        if (exp_gnt_q.size() == 0) begin
          check("gnt_unexpected", 64'(req_ready), 64'd0);
        end else begin
          int e;
          e = exp_gnt_q.pop_front();
          check("req_ready", 64'(req_ready), 64'(1) << e);
          check("grant_id", 64'(grant_id), 64'(e));
          check("busy_grant", 64'(busy), 64'd1);
          $display("grant req%0d at cycle %0d", e, cyc);
        end
      end
      if ({sl0, sl1} != 2'b11 && prev_lines == 2'b11) begin
        if (first_sym_cyc < 0) first_sym_cyc = cyc;
        if (exp_sym_q.size() == 0) check("sym_unexpected", 64'({sl0, sl1}), 64'd3);
        else check("symbol", 64'({sl0, sl1}), 64'(exp_sym_q.pop_front()));
      end
      prev_lines = {sl0, sl1};
      if (done) begin
        done_count++;
        done_cyc = cyc;
        check("busy_done", 64'(busy), 64'd0);
        if (exp_len_q.size() == 0) begin
          check("done_unexpected", 64'(exp_len_q.size()), 64'd1);
        end else begin
          int l;
          l = exp_len_q.pop_front();
          check("word_len", 64'(cyc - grant_cyc), 64'(l + 1));
          $display("done at cycle %0d length %0d", cyc, cyc - grant_cyc);
        end
      end
    end
  end

  task automatic wait_ready(input int id);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (req_ready[id]) seen = 1'b1;
    end
    check("ready_seen", 64'(seen), 64'd1);
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic run_word(input int id, input logic [31:0] d, input logic [5:0] w,
                          input bit par, input bit scramble);
    cfg_wlen = w;
    cfg_parity_en = par;
    push_word(id, d, int'(w), par);
    req_data[32*id +: 32] = d;
    @(posedge clk);
    #1;
    t0 = cyc;
    req_valid[id] = 1'b1;
    wait_ready(id);
    req_valid[id] = 1'b0;
    @(posedge clk);
    #1;
    if (scramble) begin
      cfg_wlen = 6'd20;
      cfg_parity_en = ~par;
      req_data[32*id +: 32] = ~d;
    end
    wait_done(1200);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Serve queued words; when hold is clear each requester drops valid on its ready.
  task automatic serve(input int nwords, input bit hold);
    int tg;
    int td;
    bit fin;
    tg = gnt_count + nwords;
    td = done_count + nwords;
    fin = 1'b0;
    for (int c = 0; c < nwords * 1200 + 50 && !fin; c++) begin
      @(negedge clk);
      if (!hold) req_valid = req_valid & ~req_ready;
      if (gnt_count >= tg) req_valid = '0;
      if (done_count >= td) fin = 1'b1;
    end
    check("serve_done", 64'(fin), 64'd1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_sym_q.delete();
    exp_gnt_q.delete();
    exp_len_q.delete();
    prev_lines = 2'b11;
    mon_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    cfg_enable = 1'b1;
    cfg_wlen = 6'd8;
    cfg_parity_en = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_sl0", 64'(sl0), 64'd1);
    check("rst_sl1", 64'(sl1), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reference word timing: 0xA5, 8 bits, no parity
    first_sym_cyc = -1;
    run_word(0, 32'h0000_00A5, 6'd8, 1'b0, 1'b0);
    check("t_ready", 64'(grant_cyc - t0), 64'd1);
    check("t_first_sym", 64'(first_sym_cyc - t0), 64'd2);
    check("t_done", 64'(done_cyc - t0), 64'(2 + 9 * SYM));

    // Parity words; configuration is scrambled mid-word and must not matter
    run_word(2, 32'h0000_0003, 6'd8, 1'b1, 1'b1);
    run_word(3, 32'h0000_0001, 6'd8, 1'b1, 1'b1);

    // Length clamping, with upper junk bits on the short word
    run_word(1, 32'hDEAD_BEEF, 6'd40, 1'b0, 1'b0);
    run_word(2, 32'hFFFF_FF5A, 6'd3, 1'b0, 1'b0);

    // All requesters held valid after reset: order 0,1,2,3,0
    do_reset();
    cfg_wlen = 6'd8;
    cfg_parity_en = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'h11 * (i + 1);
    for (int i = 0; i < 5; i++) push_word(i % NREQ, 32'h11 * ((i % NREQ) + 1), 8, 1'b0);
    req_valid = '1;
    serve(5, 1'b1);
    repeat (3) @(negedge clk);

    // Reset during the active phase of bit 5
    cfg_wlen = 6'd8;
    push_word(2, 32'h0000_00FF, 8, 1'b0);
    req_data[64 +: 32] = 32'h0000_00FF;
    req_valid[2] = 1'b1;
    wait_ready(2);
    req_valid[2] = 1'b0;
    repeat (165) @(negedge clk);
    check("mid_bit5_lines", 64'({sl0, sl1}), 64'd2);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_sl", 64'({sl0, sl1}), 64'd3);
    check("rst_mid_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    exp_sym_q.delete();
    exp_gnt_q.delete();
    exp_len_q.delete();
    prev_lines = 2'b11;
    mon_en = 1'b1;
    push_word(0, 32'h0000_0096, 8, 1'b0);
    push_word(3, 32'h0000_0069, 8, 1'b0);
    req_data[0 +: 32] = 32'h0000_0096;
    req_data[96 +: 32] = 32'h0000_0069;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    serve(2, 1'b0);
    repeat (3) @(negedge clk);

    // Enable dropped mid-word with req1 pending
    begin
      int r1;
      push_word(2, 32'h0000_005A, 8, 1'b0);
      req_data[64 +: 32] = 32'h0000_005A;
      req_valid[2] = 1'b1;
      wait_ready(2);
      req_valid[2] = 1'b0;
      r1 = ready1_cnt;
      req_data[32 +: 32] = 32'h0000_00C3;
      req_valid[1] = 1'b1;
      repeat (50) @(negedge clk);
      cfg_enable = 1'b0;
      wait_done(1200);
      repeat (60) @(negedge clk);
      check("no_ready1", 64'(ready1_cnt - r1), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_lines", 64'({sl0, sl1}), 64'd3);
      req_valid[1] = 1'b0;
    end

    check("sym_left", 64'(exp_sym_q.size()), 64'd0);
    check("gnt_left", 64'(exp_gnt_q.size()), 64'd0);
    check("len_left", 64'(exp_len_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sl_tx_scheduler.md
SL_TX_SCHEDULER -- requirements
Module: sl_tx_scheduler

Interface
REQ-001 Parameters SHALL be: NREQ, 4, number of requesters; BIT_CYCLES, 16, active-phase clocks per symbol; GAP_CYCLES, 16, idle-phase clocks per symbol.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  NREQ  requester i has a word pending.
REQ-005 req_data  input  32*NREQ  word of requester i in bits [32i+31:32i].
REQ-006 req_ready  output  NREQ  one-cycle accept strobe to requester i.
REQ-007 cfg_enable  input  1  permits new grants.
REQ-008 cfg_wlen  input  6  data bits per word, legal range 8..32.
REQ-009 cfg_parity_en  input  1  appends odd-parity symbol.
REQ-010 sl0  output  1  zeroes line, idle high.
REQ-011 sl1  output  1  ones line, idle high.
REQ-012 busy  output  1  high from grant until done.
REQ-013 grant_id  output  2  index of the requester being served.
REQ-014 done  output  1  one-cycle pulse at end of word.

Function
REQ-015 FSM states SHALL be IDLE, GRANT, ACTIVE, GAP, DONE; all outputs registered.
REQ-016 IDLE->GRANT when cfg_enable=1 and any req_valid=1; winner chosen round-robin, starting search at last granted index +1 mod NREQ.
REQ-017 In GRANT, req_ready[winner]=1 for exactly one cycle; req_data, cfg_wlen and cfg_parity_en captured that cycle; grant_id updated; busy=1.
REQ-018 Requesters hold req_valid and req_data stable until req_ready; valid dropped before GRANT is not served.
REQ-019 Symbol sequence: wlen data bits LSB first, then parity symbol if enabled, then one stop symbol.
REQ-020 ACTIVE lasts BIT_CYCLES clocks: data 1 -> sl1=0,sl0=1; data 0 -> sl0=0,sl1=1; stop -> both 0.
REQ-021 GAP lasts GAP_CYCLES clocks with sl0=sl1=1; GAP->ACTIVE for next symbol, GAP->DONE after stop symbol.
REQ-022 Parity symbol SHALL make the count of ones over data plus parity odd.
REQ-023 cfg_wlen<8 treated as 8, >32 treated as 32; data bits above wlen ignored.
REQ-024 Config changes during a word SHALL take effect only at the next GRANT.
REQ-025 cfg_enable deasserted mid-word: current word completes; no further grants.
REQ-026 DONE: done=1, busy=0 for one cycle, then IDLE; word duration (wlen+P+1)*(BIT_CYCLES+GAP_CYCLES) clocks, P=parity symbol count.

Reset
REQ-027 rst=1 at any clock edge SHALL force IDLE, sl0=sl1=1, req_ready=0, busy=0, done=0, grant_id=0, last-grant pointer=NREQ-1, counters 0; a word in flight is abandoned.

Configuration
REQ-028 Macro SL_TX_PARITY_EN defined: parity logic compiled in per REQ-022; undefined: cfg_parity_en ignored, no parity symbol ever sent, P=0.

Structure
REQ-029 Package sl_pkg SHALL hold FSM state typedef, WLEN_MIN=8, WLEN_MAX=32, default BIT_CYCLES/GAP_CYCLES, symbol-code typedef (ZERO, ONE, STOP, IDLE).
REQ-030 Round-robin selection SHALL be sub-module sl_rr_arbiter (request vector, pointer in; one-hot grant, index out).

Verification
REQ-031 wlen=8, parity off, req0 data 0xA5 valid at cycle 0 -> req_ready[0] cycle 1; symbols 1,0,1,0,0,1,0,1 then stop from cycle 2; done at cycle 290.
REQ-032 Parity on, wlen=8: data 0x03 -> parity symbol 1 (sl1 low); data 0x01 -> parity symbol 0 (sl0 low).
REQ-033 All four req_valid held high after reset -> grant order 0,1,2,3,0; grant_id matches each word.
REQ-034 cfg_wlen=40 -> 32 data symbols; cfg_wlen=3 -> 8 data symbols.
REQ-035 rst pulsed during ACTIVE of bit 5 -> next cycle sl0=sl1=1, busy=0; next grant goes to req0.
REQ-036 cfg_enable dropped mid-word with req1 pending -> current word completes with done; req_ready[1] never asserts.
